// File: rtl/ofdm_pilot_mapper.sv
// OFDM pilot mapper: builds NFFT-bin symbols from data subcarriers,
// inserting nulls and scrambled BPSK pilots, with backpressure both sides.
module ofdm_pilot_mapper #(
    parameter int         DW        = 16,
    parameter int         NFFT      = 64,
    parameter int         NSC_HALF  = 26,
    parameter int         PIL_A     = 7,
    parameter int         PIL_B     = 21,
    parameter int         P_AMP     = 16384,
    parameter logic [6:0] LFSR_INIT = 7'h7F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*DW-1:0] DAT_I,
    input  logic            WE_I,
    input  logic            STB_I,
    input  logic            CYC_I,
    output logic            ACK_O,
    output logic [2*DW-1:0] DAT_O,
    output logic            WE_O,
    output logic            STB_O,
    output logic            CYC_O,
    input  logic            ACK_I
);

    localparam int KW = $clog2(NFFT);

    localparam logic [KW-1:0] K_LAST = KW'(NFFT - 1);
    localparam logic [KW-1:0] K_NLO  = KW'(NSC_HALF);
    localparam logic [KW-1:0] K_NHI  = KW'(NFFT - NSC_HALF);
    localparam logic [KW-1:0] K_PA   = KW'(PIL_A);
    localparam logic [KW-1:0] K_PB   = KW'(PIL_B);
    localparam logic [KW-1:0] K_PC   = KW'(NFFT - PIL_B);
    localparam logic [KW-1:0] K_PD   = KW'(NFFT - PIL_A);

    localparam logic [DW-1:0] PIL_POS = DW'(P_AMP);
    localparam logic [DW-1:0] PIL_NEG = DW'(-P_AMP);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [KW-1:0]   r_k;
    logic [6:0]      r_lfsr;
    logic [2*DW-1:0] r_dat;
    logic            r_stb;

    logic            w_adv;
    logic            w_in;
    logic            w_null;
    logic            w_pilot;
    logic            w_data;
    logic            w_fb;
    logic            w_pneg;
    logic            w_ack;
    logic            w_load;
    logic            w_last;
    logic [2*DW-1:0] w_gen;
    logic [2*DW-1:0] w_load_val;

    assign w_adv = ~r_stb | ACK_I;
    assign w_in  = STB_I & CYC_I & WE_I;

    assign w_null  = (r_k == '0) | ((r_k > K_NLO) & (r_k < K_NHI));
    assign w_pilot = (r_k == K_PA) | (r_k == K_PB)
                   | (r_k == K_PC) | (r_k == K_PD);
    assign w_data  = ~w_null & ~w_pilot;
    assign w_last  = (r_k == K_LAST);

    // Pilot sign: base is negative only at +PIL_B, then scrambled by p_n
    assign w_fb   = r_lfsr[6] ^ r_lfsr[3];
    assign w_pneg = (r_k == K_PB) ^ w_fb;
    assign w_gen  = w_pilot ? {(w_pneg ? PIL_NEG : PIL_POS), {DW{1'b0}}}
                            : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_load      = 1'b0;
        w_load_val  = w_gen;
        unique case (r_state)
            S_IDLE: begin
                if (w_in) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_adv) begin
                    if (w_data) begin
                        w_ack      = w_in;
                        w_load     = w_in;
                        w_load_val = DAT_I;
                    end else begin
                        w_load = 1'b1;
                    end
                    if (w_load && w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k    <= '0;
            r_lfsr <= LFSR_INIT;
            r_dat  <= '0;
            r_stb  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_stb <= w_load;
            end
            if (w_load) begin
                r_dat <= w_load_val;
                r_k   <= r_k + 1'b1;
            end
            // One polarity step per completed symbol; restart between frames
            if (w_load && w_last) begin
                r_lfsr <= {r_lfsr[5:0], w_fb};
            end else if (r_state == S_IDLE && !CYC_I) begin
                r_lfsr <= LFSR_INIT;
            end
        end
    end

    assign ACK_O = w_ack;
    assign DAT_O = r_dat;
    assign STB_O = r_stb;
    assign WE_O  = r_stb;
    assign CYC_O = (r_state == S_RUN) | r_stb;

endmodule

// File: tb/tb_ofdm_pilot_mapper.sv
// Scoreboard bench for ofdm_pilot_mapper: a symbol-level model queues
// expected bins; a negedge monitor checks every downstream transfer.
module tb_ofdm_pilot_mapper;

    localparam int DW       = 16;
    localparam int NFFT     = 64;
    localparam int NSC_HALF = 26;
    localparam int PIL_A    = 7;
    localparam int PIL_B    = 21;
    localparam int P_AMP    = 16384;
    localparam int NDATA    = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   DAT_I;
    logic          WE_I;
    logic          STB_I;
    logic          CYC_I;
    logic          ACK_O;
    logic [31:0]   DAT_O;
    logic          WE_O;
    logic          STB_O;
    logic          CYC_O;
    logic          ACK_I;

    always #5 clk = ~clk;

    ofdm_pilot_mapper #(
        .DW(DW), .NFFT(NFFT), .NSC_HALF(NSC_HALF),
        .PIL_A(PIL_A), .PIL_B(PIL_B), .P_AMP(P_AMP),
        .LFSR_INIT(7'h7F)
    ) dut (
        .clk(clk), .rst(rst),
        .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I),
        .ACK_O(ACK_O),
        .DAT_O(DAT_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O),
        .ACK_I(ACK_I)
    );

    int          n_pass = 0;
    int          n_tot  = 0;
    logic [31:0] exp_q[$];
    int          pol[127];
    int          pidx = 0;
    int          ack_mode = 1;
    bit          hold = 0;
    logic [31:0] held_dat;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    endtask

    function automatic void init_pol();
        bit [6:0] s = 7'h7F;
        bit b;
        for (int i = 0; i < 127; i++) begin
            b = s[6] ^ s[3];
            pol[i] = b ? -1 : 1;
            s = {s[5:0], b};
        end
    endfunction

    function automatic logic [31:0] pack(input int i, input int q);
        logic [15:0] a;
        logic [15:0] b;
        a = i[15:0];
        b = q[15:0];
        return {a, b};
    endfunction

    // Expected symbol from bin classes, base signs and this frame's p_n
    task automatic push_symbol(input logic [31:0] smp[NDATA]);
        int p = pol[pidx];
        int d = 0;
        int base;
        for (int k = 0; k < NFFT; k++) begin
            if (k == 0 || (k > NSC_HALF && k < NFFT - NSC_HALF)) begin
                exp_q.push_back(32'h0);
            end else if (k == PIL_A || k == PIL_B ||
                         k == NFFT - PIL_B || k == NFFT - PIL_A) begin
                base = (k == PIL_B) ? -1 : 1;
                exp_q.push_back(pack(base * p * P_AMP, 0));
            end else begin
                exp_q.push_back(smp[d]);
                d++;
            end
        end
        pidx = (pidx + 1) % 127;
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer(input logic [31:0] d);
        int t = 0;
        DAT_I = d;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        forever begin
            @(negedge clk);
            if (ACK_O) break;
            t++;
            if (t > 3000) begin
                n_tot++;
                $display("FAIL ack_timeout: no ACK_O in %0d cycles, expected one", t);
                finish_run();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_symbol(input bit ramp, input int stall_at,
                               input int gap_at, input bit cyc_drop,
                               input int abort_at);
        logic [31:0] smp[NDATA];
        int          sv;
        for (int i = 0; i < NDATA; i++)
            smp[i] = ramp ? pack(i + 1, -(i + 1)) : $urandom();
        push_symbol(smp);
        CYC_I = 1'b1;
        for (int i = 0; i < NDATA; i++) begin
            if (i == abort_at) return;
            if (i == stall_at) begin
                sv = ack_mode;
                ack_mode = 2;
                cyc_wait(7);
                ack_mode = sv;
            end
            if (i == gap_at) begin
                STB_I = 1'b0;
                cyc_wait(5);
            end
            if (cyc_drop && i == 20) begin
                STB_I = 1'b0;
                CYC_I = 1'b0;
                cyc_wait(3);
                CYC_I = 1'b1;
            end
            if (!ramp && $urandom_range(0, 9) == 0) begin
                STB_I = 1'b0;
                cyc_wait($urandom_range(1, 4));
            end
            xfer(smp[i]);
        end
        STB_I = 1'b0;
    endtask

    task automatic frame_gap();
        CYC_I = 1'b0;
        cyc_wait(3);
        pidx = 0;
    endtask

    task automatic reset_mid();
        int sv = ack_mode;
        ack_mode = 2;
        STB_I = 1'b0;
        cyc_wait(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_stb", STB_O, 0);
        chk("rst_mid_cyc", CYC_O, 0);
        chk("rst_mid_dat", DAT_O, 0);
        rst = 1'b0;
        exp_q.delete();
        pidx = 0;
        ack_mode = sv;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ack_mode)
                0:       ACK_I = ($urandom_range(0, 3) != 0);
                1:       ACK_I = 1'b1;
                default: ACK_I = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                chk("we_eq_stb", WE_O, STB_O);
                if (STB_O) chk("cyc_with_stb", CYC_O, 1);
                if (hold) begin
                    chk("hold_stb", STB_O, 1);
                    chk("hold_dat", DAT_O, held_dat);
                end
                if (STB_O && !ACK_I) chk("ack_o_blocked", ACK_O, 0);
                if (STB_O && ACK_I) begin
                    if (exp_q.size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_out: got %h expected none", DAT_O);
                    end else begin
                        chk("bin", DAT_O, exp_q.pop_front());
                    end
                end
                hold = STB_O && !ACK_I;
                held_dat = DAT_O;
            end
        end
    end

    initial begin
        int t;
        init_pol();
        rst = 1'b1;
        DAT_I = '0;
        WE_I = 1'b0;
        STB_I = 1'b0;
        CYC_I = 1'b0;
        ACK_I = 1'b0;
        cyc_wait(3);
        chk("rst_stb", STB_O, 0);
        chk("rst_cyc", CYC_O, 0);
        chk("rst_we", WE_O, 0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_ack", ACK_O, 0);
        rst = 1'b0;
        cyc_wait(2);

        ack_mode = 1;
        send_symbol(1, -1, -1, 0, -1);
        for (int s = 0; s < 7; s++) send_symbol(0, -1, -1, 0, -1);

        frame_gap();
        send_symbol(0, -1, -1, 0, -1);
        send_symbol(0, -1, -1, 0, -1);
        frame_gap();
        send_symbol(0, -1, -1, 0, -1);

        send_symbol(0, 8, -1, 0, -1);
        send_symbol(0, -1, 24, 0, -1);
        send_symbol(0, -1, -1, 1, -1);

        ack_mode = 0;
        for (int s = 0; s < 6; s++) begin
            send_symbol(0, -1, -1, s[0], -1);
            if ($urandom_range(0, 2) == 0) frame_gap();
        end

        send_symbol(0, -1, -1, 0, 26);
        reset_mid();
        send_symbol(0, -1, -1, 0, -1);
        send_symbol(0, 8, 24, 0, -1);

        ack_mode = 1;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            cyc_wait(1);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        cyc_wait(3);
        chk("end_cyc", CYC_O, 0);
        chk("end_stb", STB_O, 0);
        finish_run();
    end

endmodule
